id_ex_stage: RTL

ID_EX_STAGE -- requirements
Module: id_ex_stage

---
 rtl/pipe_pkg.sv | 20 ++
 rtl/hazard_detect.sv | 24 ++
 rtl/id_ex_stage.sv | 126 ++++++++++++
 3 files changed

// File: rtl/pipe_pkg.sv
`default_nettype none
// pipe_pkg: control-word bit positions and datapath widths shared by the
// ID/EX and MEM/WB stages and the RegFile wrapper.
package pipe_pkg;

  localparam int CTRL_W        = 8;
  localparam int REG_ADDR_W    = 5;
  localparam int DATA_W        = 32;

  localparam int CTRL_REGWRITE = 7;
  localparam int CTRL_MEMREAD  = 6;
  localparam int CTRL_MEMWRITE = 5;
  localparam int CTRL_MEMTOREG = 4;
  localparam int CTRL_REGDST   = 3;
  localparam int CTRL_ALUSRC   = 2;
  localparam int CTRL_ALUOP_HI = 1;
  localparam int CTRL_ALUOP_LO = 0;

endpackage : pipe_pkg
`default_nettype wire

// File: rtl/hazard_detect.sv
`default_nettype none
// hazard_detect: flags a load in EX whose destination (rt) is read by the
// instruction in ID. Register $0 never creates a dependency.
module hazard_detect
  import pipe_pkg::*;
(
  input  logic                  ex_valid,
  input  logic                  ex_memread,
  input  logic [REG_ADDR_W-1:0] ex_rt,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  output logic                  load_use
);

  logic rt_nonzero;
  logic rt_match;

  assign rt_nonzero = (ex_rt != '0);
  assign rt_match   = (ex_rt == id_rs) | (ex_rt == id_rt);
  assign load_use   = ex_valid & ex_memread & rt_nonzero & id_valid & rt_match;

endmodule : hazard_detect
`default_nettype wire

// File: rtl/id_ex_stage.sv
`default_nettype none
// id_ex_stage: ID/EX pipeline register with flush/stall bubble insertion.
// Load-use stall and its counter exist only when ID_EX_HAZARD_STALL_EN is defined.
module id_ex_stage
  import pipe_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  id_valid,
  input  logic [DATA_W-1:0]     id_readdata1,
  input  logic [DATA_W-1:0]     id_readdata2,
  input  logic [REG_ADDR_W-1:0] id_rs,
  input  logic [REG_ADDR_W-1:0] id_rt,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic [DATA_W-1:0]     id_imm,
  input  logic [CTRL_W-1:0]     id_ctrl,
  input  logic                  flush,
  output logic                  ex_valid,
  output logic [DATA_W-1:0]     ex_readdata1,
  output logic [DATA_W-1:0]     ex_readdata2,
  output logic [REG_ADDR_W-1:0] ex_rs,
  output logic [REG_ADDR_W-1:0] ex_rt,
  output logic [REG_ADDR_W-1:0] ex_rd,
  output logic [DATA_W-1:0]     ex_imm,
  output logic [CTRL_W-1:0]     ex_ctrl,
  output logic                  stall,
  output logic [CNT_W-1:0]      stall_count
);

  logic                  ex_valid_q,     ex_valid_d;
  logic [DATA_W-1:0]     ex_readdata1_q, ex_readdata1_d;
  logic [DATA_W-1:0]     ex_readdata2_q, ex_readdata2_d;
  logic [REG_ADDR_W-1:0] ex_rs_q,        ex_rs_d;
  logic [REG_ADDR_W-1:0] ex_rt_q,        ex_rt_d;
  logic [REG_ADDR_W-1:0] ex_rd_q,        ex_rd_d;
  logic [DATA_W-1:0]     ex_imm_q,       ex_imm_d;
  logic [CTRL_W-1:0]     ex_ctrl_q,      ex_ctrl_d;
  logic                  bubble;

`ifdef ID_EX_HAZARD_STALL_EN
  logic             load_use;
  logic [CNT_W-1:0] stall_count_q, stall_count_d;

  hazard_detect u_hazard_detect (
    .ex_valid   (ex_valid_q),
    .ex_memread (ex_ctrl_q[CTRL_MEMREAD]),
    .ex_rt      (ex_rt_q),
    .id_valid   (id_valid),
    .id_rs      (id_rs),
    .id_rt      (id_rt),
    .load_use   (load_use)
  );

  // Flush wins: a squashed instruction has no dependency worth waiting for.
  assign stall = load_use & ~flush;

  always_comb begin
    stall_count_d = stall_count_q;
    if (stall && (stall_count_q != {CNT_W{1'b1}})) begin
      stall_count_d = stall_count_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stall_count_q <= '0;
    end else begin
      stall_count_q <= stall_count_d;
    end
  end

  assign stall_count = stall_count_q;
`else
  assign stall       = 1'b0;
  assign stall_count = '0;
`endif

  assign bubble = flush | stall;

  // A bubble kills valid/ctrl but leaves the datapath fields untouched.
  always_comb begin
    ex_valid_d     = bubble ? 1'b0 : id_valid;
    ex_ctrl_d      = bubble ? '0   : id_ctrl;
    ex_readdata1_d = bubble ? ex_readdata1_q : id_readdata1;
    ex_readdata2_d = bubble ? ex_readdata2_q : id_readdata2;
    ex_rs_d        = bubble ? ex_rs_q        : id_rs;
    ex_rt_d        = bubble ? ex_rt_q        : id_rt;
    ex_rd_d        = bubble ? ex_rd_q        : id_rd;
    ex_imm_d       = bubble ? ex_imm_q       : id_imm;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_valid_q     <= 1'b0;
      ex_ctrl_q      <= '0;
      ex_readdata1_q <= '0;
      ex_readdata2_q <= '0;
      ex_rs_q        <= '0;
      ex_rt_q        <= '0;
      ex_rd_q        <= '0;
      ex_imm_q       <= '0;
    end else begin
      ex_valid_q     <= ex_valid_d;
      ex_ctrl_q      <= ex_ctrl_d;
      ex_readdata1_q <= ex_readdata1_d;
      ex_readdata2_q <= ex_readdata2_d;
      ex_rs_q        <= ex_rs_d;
      ex_rt_q        <= ex_rt_d;
      ex_rd_q        <= ex_rd_d;
      ex_imm_q       <= ex_imm_d;
    end
  end

  assign ex_valid     = ex_valid_q;
  assign ex_ctrl      = ex_ctrl_q;
  assign ex_readdata1 = ex_readdata1_q;
  assign ex_readdata2 = ex_readdata2_q;
  assign ex_rs        = ex_rs_q;
  assign ex_rt        = ex_rt_q;
  assign ex_rd        = ex_rd_q;
  assign ex_imm       = ex_imm_q;

endmodule : id_ex_stage
`default_nettype wire
